tlb_mmu: RTL

16-entry fully-associative joint TLB and virtual-to-physical address translator that sits directly beside the CP0 register block. It consumes CP0 EntryHi/EntryLo0/EntryLo1/Index/Random/Status, executes TLBP/TLBR/TLBWI/TLBWR, and translates one fetch or data address per cycle. It returns probe results, TLBR data and TLB/address-error exceptions to CP0 through CP0's `*_i` / `*_wen_i` / `exception_*_i` inputs.

---
 rtl/tlb_mmu.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_mmu.sv
// tlb_mmu
// Fully-associative joint TLB and virtual-to-physical translator living
// next to the CP0 register block.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   cpu_pause_i         stall; freezes state and suppresses all strobes
//   lookup_*_i          one translation request per cycle (vaddr, store, size)
//   status_um_i/exl_i   CP0 Status bits used for the user-mode segment check
//   tlbp/tlbr/tlbwi/tlbwr_i  decoded TLB instructions
//   cp0_*_i             current CP0 Index, Random, EntryHi, EntryLo0/1
//   lookup_valid_o      one-cycle result strobe for a translation
//   lookup_paddr_o, lookup_cached_o  translation result
//   exception_*_o, badvaddr_o        exception report to CP0
//   tlb_probe_*_o       TLBP result and strobe
//   cp0_entry*_o/_wen_o write-back data and strobes to CP0 EntryHi/Lo
module tlb_mmu #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_pause_i,
  input  logic        lookup_req_i,
  input  logic [31:0] lookup_vaddr_i,
  input  logic        lookup_store_i,
  input  logic [1:0]  lookup_size_i,
  input  logic        status_um_i,
  input  logic        status_exl_i,
  input  logic        tlbp_i,
  input  logic        tlbr_i,
  input  logic        tlbwi_i,
  input  logic        tlbwr_i,
  input  logic [3:0]  cp0_index_i,
  input  logic [3:0]  cp0_random_i,
  input  logic [31:0] cp0_entryhi_i,
  input  logic [31:0] cp0_entrylo0_i,
  input  logic [31:0] cp0_entrylo1_i,
  output logic        lookup_valid_o,
  output logic [31:0] lookup_paddr_o,
  output logic        lookup_cached_o,
  output logic        exception_addr_error_o,
  output logic        exception_tlb_refill_o,
  output logic        exception_tlb_invalid_o,
  output logic        exception_tlb_mod_o,
  output logic        exception_tlb_rw_o,
  output logic [31:0] badvaddr_o,
  output logic        tlb_probe_failed_o,
  output logic [3:0]  tlb_probe_index_o,
  output logic        tlb_probe_wen_o,
  output logic [31:0] cp0_entryhi_o,
  output logic [31:0] cp0_entrylo0_o,
  output logic [31:0] cp0_entrylo1_o,
  output logic        cp0_entryhi_wen_o,
  output logic        cp0_entrylo0_wen_o,
  output logic        cp0_entrylo1_wen_o
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  tlb_entry_t entry_q [ENTRIES];
  tlb_entry_t entry_d [ENTRIES];
  tlb_entry_t new_entry;

  logic        lk_hit;
  logic [3:0]  lk_idx;
  logic        pr_hit;
  logic [3:0]  pr_idx;
  logic [19:0] lk_pfn;
  logic [2:0]  lk_c;
  logic        lk_d;
  logic        lk_v;
  logic        misaligned;
  logic        addr_err;
  logic        mapped;

  logic        valid_q, valid_d;
  logic [31:0] paddr_q, paddr_d;
  logic        cached_q, cached_d;
  logic        exc_addr_q, exc_addr_d;
  logic        exc_refill_q, exc_refill_d;
  logic        exc_invalid_q, exc_invalid_d;
  logic        exc_mod_q, exc_mod_d;
  logic        exc_rw_q, exc_rw_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        probe_failed_q, probe_failed_d;
  logic [3:0]  probe_index_q, probe_index_d;
  logic        probe_wen_q, probe_wen_d;
  logic [31:0] ehi_q, ehi_d;
  logic [31:0] elo0_q, elo0_d;
  logic [31:0] elo1_q, elo1_d;
  logic        ehi_wen_q, ehi_wen_d;
  logic        elo0_wen_q, elo0_wen_d;
  logic        elo1_wen_q, elo1_wen_d;

  // EntryHi[12:8] and the EntryLo bits above PFN carry nothing the TLB stores.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_entryhi_i[12:8], cp0_entrylo0_i[31:26],
                             cp0_entrylo1_i[31:26]};

  // Entry image built from the CP0 registers for TLBWI/TLBWR; the global bit
  // is only honoured when both halves of the pair agree on it.
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = cp0_entryhi_i[31:13];
    new_entry.asid = cp0_entryhi_i[7:0];
    new_entry.g    = cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
    new_entry.pfn0 = cp0_entrylo0_i[25:6];
    new_entry.c0   = cp0_entrylo0_i[5:3];
    new_entry.d0   = cp0_entrylo0_i[2];
    new_entry.v0   = cp0_entrylo0_i[1];
    new_entry.pfn1 = cp0_entrylo1_i[25:6];
    new_entry.c1   = cp0_entrylo1_i[5:3];
    new_entry.d1   = cp0_entrylo1_i[2];
    new_entry.v1   = cp0_entrylo1_i[1];
  end

  // Associative match for the translation port and for TLBP. Scanning from
  // the top index down lets the lowest matching index overwrite the others.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_q[i].vpn2 == lookup_vaddr_i[31:13] &&
          (entry_q[i].g || entry_q[i].asid == cp0_entryhi_i[7:0])) begin
        lk_hit = 1'b1;
        lk_idx = 4'(i);
      end
      if (entry_q[i].vpn2 == cp0_entryhi_i[31:13] &&
          (entry_q[i].g || entry_q[i].asid == cp0_entryhi_i[7:0])) begin
        pr_hit = 1'b1;
        pr_idx = 4'(i);
      end
    end
  end

  // Even/odd page half of the winning entry, chosen by vaddr[12].
  always_comb begin
    if (lookup_vaddr_i[12]) begin
      lk_pfn = entry_q[lk_idx].pfn1;
      lk_c   = entry_q[lk_idx].c1;
      lk_d   = entry_q[lk_idx].d1;
      lk_v   = entry_q[lk_idx].v1;
    end else begin
      lk_pfn = entry_q[lk_idx].pfn0;
      lk_c   = entry_q[lk_idx].c0;
      lk_d   = entry_q[lk_idx].d0;
      lk_v   = entry_q[lk_idx].v0;
    end
  end

  // Address-error and segment classification of the request.
  always_comb begin
    misaligned = ((lookup_size_i == 2'd1) && lookup_vaddr_i[0]) ||
                 ((lookup_size_i[1]) && (lookup_vaddr_i[1:0] != 2'b00));
    addr_err   = misaligned ||
                 (status_um_i && !status_exl_i && lookup_vaddr_i[31]);
    mapped     = !lookup_vaddr_i[31] || (lookup_vaddr_i[31:30] == 2'b11);
  end

  // Next-state logic. Paused cycles hold everything and drop the strobes.
  // The instruction chain executes only its highest-priority member, and the
  // lookup is evaluated last so an exception's EntryHi write overrides TLBR.
  always_comb begin
    entry_d        = entry_q;
    valid_d        = 1'b0;
    probe_wen_d    = 1'b0;
    ehi_wen_d      = 1'b0;
    elo0_wen_d     = 1'b0;
    elo1_wen_d     = 1'b0;
    paddr_d        = paddr_q;
    cached_d       = cached_q;
    exc_addr_d     = exc_addr_q;
    exc_refill_d   = exc_refill_q;
    exc_invalid_d  = exc_invalid_q;
    exc_mod_d      = exc_mod_q;
    exc_rw_d       = exc_rw_q;
    badvaddr_d     = badvaddr_q;
    probe_failed_d = probe_failed_q;
    probe_index_d  = probe_index_q;
    ehi_d          = ehi_q;
    elo0_d         = elo0_q;
    elo1_d         = elo1_q;

    if (!cpu_pause_i) begin
      exc_addr_d    = 1'b0;
      exc_refill_d  = 1'b0;
      exc_invalid_d = 1'b0;
      exc_mod_d     = 1'b0;

      if (tlbwi_i) begin
        entry_d[cp0_index_i] = new_entry;
      end else if (tlbwr_i) begin
        entry_d[cp0_random_i] = new_entry;
      end else if (tlbr_i) begin
        ehi_d      = {entry_q[cp0_index_i].vpn2, 5'b0, entry_q[cp0_index_i].asid};
        elo0_d     = {6'b0, entry_q[cp0_index_i].pfn0, entry_q[cp0_index_i].c0,
                      entry_q[cp0_index_i].d0, entry_q[cp0_index_i].v0,
                      entry_q[cp0_index_i].g};
        elo1_d     = {6'b0, entry_q[cp0_index_i].pfn1, entry_q[cp0_index_i].c1,
                      entry_q[cp0_index_i].d1, entry_q[cp0_index_i].v1,
                      entry_q[cp0_index_i].g};
        ehi_wen_d  = 1'b1;
        elo0_wen_d = 1'b1;
        elo1_wen_d = 1'b1;
      end else if (tlbp_i) begin
        probe_wen_d    = 1'b1;
        probe_failed_d = !pr_hit;
        probe_index_d  = pr_hit ? pr_idx : 4'd0;
      end

      if (lookup_req_i) begin
        valid_d = 1'b1;
        if (addr_err) begin
          exc_addr_d = 1'b1;
        end else if (mapped) begin
          if (!lk_hit) begin
            exc_refill_d = 1'b1;
          end else if (!lk_v) begin
            exc_invalid_d = 1'b1;
          end else if (lookup_store_i && !lk_d) begin
            exc_mod_d = 1'b1;
          end
        end

        if (exc_addr_d || exc_refill_d || exc_invalid_d || exc_mod_d) begin
          paddr_d    = '0;
          cached_d   = 1'b0;
          exc_rw_d   = lookup_store_i;
          badvaddr_d = lookup_vaddr_i;
          if (!exc_addr_d) begin
            ehi_d     = {lookup_vaddr_i[31:13], 5'b0, cp0_entryhi_i[7:0]};
            ehi_wen_d = 1'b1;
          end
        end else if (mapped) begin
          paddr_d  = {lk_pfn, lookup_vaddr_i[11:0]};
          cached_d = (lk_c == 3'd3);
        end else begin
          paddr_d  = lookup_vaddr_i & 32'h1FFF_FFFF;
          cached_d = !lookup_vaddr_i[29];
        end
      end
    end
  end

  // State register. Reset invalidates every entry and zeroes all outputs,
  // which also discards any strobe that was about to be issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      valid_q        <= 1'b0;
      paddr_q        <= '0;
      cached_q       <= 1'b0;
      exc_addr_q     <= 1'b0;
      exc_refill_q   <= 1'b0;
      exc_invalid_q  <= 1'b0;
      exc_mod_q      <= 1'b0;
      exc_rw_q       <= 1'b0;
      badvaddr_q     <= '0;
      probe_failed_q <= 1'b0;
      probe_index_q  <= '0;
      probe_wen_q    <= 1'b0;
      ehi_q          <= '0;
      elo0_q         <= '0;
      elo1_q         <= '0;
      ehi_wen_q      <= 1'b0;
      elo0_wen_q     <= 1'b0;
      elo1_wen_q     <= 1'b0;
    end else begin
      entry_q        <= entry_d;
      valid_q        <= valid_d;
      paddr_q        <= paddr_d;
      cached_q       <= cached_d;
      exc_addr_q     <= exc_addr_d;
      exc_refill_q   <= exc_refill_d;
      exc_invalid_q  <= exc_invalid_d;
      exc_mod_q      <= exc_mod_d;
      exc_rw_q       <= exc_rw_d;
      badvaddr_q     <= badvaddr_d;
      probe_failed_q <= probe_failed_d;
      probe_index_q  <= probe_index_d;
      probe_wen_q    <= probe_wen_d;
      ehi_q          <= ehi_d;
      elo0_q         <= elo0_d;
      elo1_q         <= elo1_d;
      ehi_wen_q      <= ehi_wen_d;
      elo0_wen_q     <= elo0_wen_d;
      elo1_wen_q     <= elo1_wen_d;
    end
  end

  assign lookup_valid_o          = valid_q;
  assign lookup_paddr_o          = paddr_q;
  assign lookup_cached_o         = cached_q;
  assign exception_addr_error_o  = exc_addr_q;
  assign exception_tlb_refill_o  = exc_refill_q;
  assign exception_tlb_invalid_o = exc_invalid_q;
  assign exception_tlb_mod_o     = exc_mod_q;
  assign exception_tlb_rw_o      = exc_rw_q;
  assign badvaddr_o              = badvaddr_q;
  assign tlb_probe_failed_o      = probe_failed_q;
  assign tlb_probe_index_o       = probe_index_q;
  assign tlb_probe_wen_o         = probe_wen_q;
  assign cp0_entryhi_o           = ehi_q;
  assign cp0_entrylo0_o          = elo0_q;
  assign cp0_entrylo1_o          = elo1_q;
  assign cp0_entryhi_wen_o       = ehi_wen_q;
  assign cp0_entrylo0_wen_o      = elo0_wen_q;
  assign cp0_entrylo1_wen_o      = elo1_wen_q;

endmodule
